// File: rtl/uart_param_core.sv
// UART TX/RX engine with shared acquisition-tick divider, configurable frame format,
// show-ahead TX/RX FIFOs and per-entry RX error tags, presented as valid/ready streams.
//
// TX state | meaning                       RX state | meaning
// TX_IDLE  | line idle, may hold a byte    RX_IDLE  | waiting for falling edge
// TX_START | driving start bit             RX_START | checking start bit
// TX_DATA  | shifting data LSB first       RX_DATA  | sampling data bits
// TX_PAR   | driving parity bit            RX_PAR   | sampling parity bit
// TX_STOP1 | first stop bit                RX_STOP  | sampling stop bit, write FIFO
// TX_STOP2 | second stop bit               RX_WAITH | after break, wait for line high
module uart_param_core #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int ACQ_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ACQ_W-1:0]              cfg_acq_period_i,
   input  logic [3:0]                    cfg_acq_per_bit_i,
   input  logic                          cfg_parity_en_i,
   input  logic                          cfg_parity_odd_i,
   input  logic                          cfg_stop2_i,
   input  logic                          cfg_loopback_i,
   input  logic                          clr_i,
   input  logic [DATA_W-1:0]             tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level_o,
   output logic                          tx_busy_o,
   output logic [DATA_W-1:0]             rx_data_o,
   output logic                          rx_parity_err_o,
   output logic                          rx_frame_err_o,
   output logic                          rx_valid_o,
   input  logic                          rx_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
   output logic                          rx_overrun_o,
   output logic                          rx_break_o,
   input  logic                          rx_i,
   output logic                          tx_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]       CNT_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
   localparam logic [ACQ_W-1:0]  ACQ_ONE  = ACQ_W'(1);
   localparam logic [3:0]        BMAX     = 4'(DATA_W-1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_st_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAITH} rx_st_t;

   // acquisition tick and per-bit tick count
   logic [ACQ_W-1:0] r_acq_cnt, w_acq_last;
   logic             w_tick;
   logic [3:0]       w_n, w_nm1, w_half;

   assign w_acq_last = (cfg_acq_period_i == '0) ? '0 : cfg_acq_period_i - ACQ_ONE;
   assign w_tick     = (r_acq_cnt >= w_acq_last);
   assign w_n        = (cfg_acq_per_bit_i < 4'd4) ? 4'd4 : cfg_acq_per_bit_i;
   assign w_nm1      = w_n - 4'd1;
   assign w_half     = {1'b0, w_n[3:1]};

   always_ff @(posedge clk) begin
      if (rst || w_tick) r_acq_cnt <= '0;
      else               r_acq_cnt <= r_acq_cnt + ACQ_ONE;
   end

   // TX FIFO
   logic [DATA_W-1:0] r_txf_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_txf_wp, r_txf_rp;
   logic [AW:0]       r_txf_cnt;
   logic              w_txf_full, w_txf_empty, w_txf_wr, w_tx_pop;
   logic [DATA_W-1:0] w_txf_head;

   assign w_txf_full  = (r_txf_cnt == CNT_FULL);
   assign w_txf_empty = (r_txf_cnt == '0);
   assign w_txf_wr    = tx_valid_i && (!w_txf_full || w_tx_pop);
   assign w_txf_head  = r_txf_mem[r_txf_rp];
   assign tx_ready_o  = !w_txf_full;
   assign tx_level_o  = r_txf_cnt;

   always_ff @(posedge clk) begin
      if (w_txf_wr) r_txf_mem[r_txf_wp] <= tx_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         r_txf_wp  <= '0;
         r_txf_rp  <= '0;
         r_txf_cnt <= '0;
      end else begin
         if (w_txf_wr) r_txf_wp <= r_txf_wp + PTR_ONE;
         if (w_tx_pop) r_txf_rp <= r_txf_rp + PTR_ONE;
         case ({w_txf_wr, w_tx_pop})
            2'b10:   r_txf_cnt <= r_txf_cnt + CNT_ONE;
            2'b01:   r_txf_cnt <= r_txf_cnt - CNT_ONE;
            default: r_txf_cnt <= r_txf_cnt;
         endcase
      end
   end

   // TX engine
   tx_st_t            r_tx_st, w_tx_nxt;
   logic              r_tx_have, r_tx_par, r_tx_par_en, r_tx_stop2, r_tx_o, r_tx_line;
   logic [3:0]        r_tx_tcnt, r_tx_bcnt, r_tx_nm1;
   logic [DATA_W-1:0] r_tx_sh;
   logic              w_tx_bit_end, w_tx_last_end, w_tx_line;

   assign w_tx_bit_end  = w_tick && (r_tx_tcnt == r_tx_nm1);
   assign w_tx_last_end = w_tx_bit_end &&
                          ((r_tx_st == TX_STOP1 && !r_tx_stop2) || r_tx_st == TX_STOP2);

   always_ff @(posedge clk) begin
      if (rst || clr_i) r_tx_st <= TX_IDLE;
      else              r_tx_st <= w_tx_nxt;
   end

   always_comb begin
      w_tx_nxt = r_tx_st;
      case (r_tx_st)
         TX_IDLE:  if (r_tx_have && w_tick) w_tx_nxt = TX_START;
         TX_START: if (w_tx_bit_end) w_tx_nxt = TX_DATA;
         TX_DATA:  if (w_tx_bit_end && r_tx_bcnt == BMAX)
                      w_tx_nxt = r_tx_par_en ? TX_PAR : TX_STOP1;
         TX_PAR:   if (w_tx_bit_end) w_tx_nxt = TX_STOP1;
         TX_STOP1: if (w_tx_bit_end)
                      w_tx_nxt = r_tx_stop2 ? TX_STOP2 : (w_txf_empty ? TX_IDLE : TX_START);
         TX_STOP2: if (w_tx_bit_end) w_tx_nxt = w_txf_empty ? TX_IDLE : TX_START;
         default:  w_tx_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      w_tx_pop  = !w_txf_empty && ((r_tx_st == TX_IDLE && !r_tx_have) || w_tx_last_end);
      tx_busy_o = (r_tx_st != TX_IDLE);
      case (r_tx_st)
         TX_START: w_tx_line = 1'b0;
         TX_DATA:  w_tx_line = r_tx_sh[0];
         TX_PAR:   w_tx_line = r_tx_par;
         default:  w_tx_line = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         r_tx_have   <= 1'b0;
         r_tx_tcnt   <= '0;
         r_tx_bcnt   <= '0;
         r_tx_sh     <= '0;
         r_tx_par    <= 1'b0;
         r_tx_par_en <= 1'b0;
         r_tx_stop2  <= 1'b0;
         r_tx_nm1    <= 4'd3;
         r_tx_o      <= 1'b1;
         r_tx_line   <= 1'b1;
      end else begin
         r_tx_line <= w_tx_line;
         r_tx_o    <= cfg_loopback_i | w_tx_line;
         if (w_tx_pop) begin
            r_tx_sh     <= w_txf_head;
            r_tx_par    <= (^w_txf_head) ^ cfg_parity_odd_i;
            r_tx_par_en <= cfg_parity_en_i;
            r_tx_stop2  <= cfg_stop2_i;
            r_tx_nm1    <= w_nm1;
         end else if (r_tx_st == TX_DATA && w_tx_bit_end) begin
            r_tx_sh <= r_tx_sh >> 1;
         end
         if (w_tx_pop && r_tx_st == TX_IDLE) r_tx_have <= 1'b1;
         else if (w_tx_nxt != TX_IDLE)       r_tx_have <= 1'b0;
         if (r_tx_st == TX_IDLE) r_tx_tcnt <= '0;
         else if (w_tick)        r_tx_tcnt <= (r_tx_tcnt == r_tx_nm1) ? 4'd0 : r_tx_tcnt + 4'd1;
         if (r_tx_st != TX_DATA)  r_tx_bcnt <= '0;
         else if (w_tx_bit_end)   r_tx_bcnt <= r_tx_bcnt + 4'd1;
      end
   end

   assign tx_o = r_tx_o;

   // RX input synchroniser; third flop only provides the edge reference
   logic w_rx_src, r_rx_s1, r_rx_s2, r_rx_d, w_rx_fall;

   assign w_rx_src  = cfg_loopback_i ? r_tx_line : rx_i;
   assign w_rx_fall = r_rx_d & ~r_rx_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_rx_s1 <= w_rx_src;
         r_rx_s2 <= r_rx_s1;
         r_rx_d  <= r_rx_s2;
      end
   end

   // RX engine
   rx_st_t            r_rx_st, w_rx_nxt;
   logic [3:0]        r_rx_tcnt, r_rx_bcnt, r_rx_nm1, r_rx_half;
   logic [DATA_W-1:0] r_rx_sh;
   logic              r_rx_par_en, r_rx_odd, r_rx_par_s, r_rx_break;
   logic              w_rx_samp, w_rx_bit_end, w_rx_is_brk, w_rx_par_err;
   logic              w_rx_push, w_rx_brk_evt;

   assign w_rx_samp    = w_tick && (r_rx_tcnt == r_rx_half);
   assign w_rx_bit_end = w_tick && (r_rx_tcnt == r_rx_nm1);
   assign w_rx_is_brk  = !r_rx_s2 && (r_rx_sh == '0) && (!r_rx_par_en || !r_rx_par_s);
   assign w_rx_par_err = r_rx_par_en & ((^r_rx_sh) ^ r_rx_odd ^ r_rx_par_s);

   always_ff @(posedge clk) begin
      if (rst || clr_i) r_rx_st <= RX_IDLE;
      else              r_rx_st <= w_rx_nxt;
   end

   always_comb begin
      w_rx_nxt = r_rx_st;
      case (r_rx_st)
         RX_IDLE:  if (w_rx_fall) w_rx_nxt = RX_START;
         RX_START: if (w_rx_samp && r_rx_s2) w_rx_nxt = RX_IDLE;
                   else if (w_rx_bit_end)    w_rx_nxt = RX_DATA;
         RX_DATA:  if (w_rx_bit_end && r_rx_bcnt == BMAX)
                      w_rx_nxt = r_rx_par_en ? RX_PAR : RX_STOP;
         RX_PAR:   if (w_rx_bit_end) w_rx_nxt = RX_STOP;
         RX_STOP:  if (w_rx_samp) w_rx_nxt = w_rx_is_brk ? RX_WAITH : RX_IDLE;
         RX_WAITH: if (r_rx_s2) w_rx_nxt = RX_IDLE;
         default:  w_rx_nxt = RX_IDLE;
      endcase
   end

   always_comb begin
      w_rx_push    = (r_rx_st == RX_STOP) && w_rx_samp && !w_rx_is_brk;
      w_rx_brk_evt = (r_rx_st == RX_STOP) && w_rx_samp && w_rx_is_brk;
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         r_rx_tcnt   <= '0;
         r_rx_bcnt   <= '0;
         r_rx_sh     <= '0;
         r_rx_nm1    <= 4'd3;
         r_rx_half   <= 4'd2;
         r_rx_par_en <= 1'b0;
         r_rx_odd    <= 1'b0;
         r_rx_par_s  <= 1'b0;
         r_rx_break  <= 1'b0;
      end else begin
         r_rx_break <= w_rx_brk_evt;
         if (r_rx_st == RX_IDLE && w_rx_fall) begin
            r_rx_nm1    <= w_nm1;
            r_rx_half   <= w_half;
            r_rx_par_en <= cfg_parity_en_i;
            r_rx_odd    <= cfg_parity_odd_i;
         end
         if (r_rx_st == RX_IDLE || r_rx_st == RX_WAITH) r_rx_tcnt <= '0;
         else if (w_tick) r_rx_tcnt <= (r_rx_tcnt == r_rx_nm1) ? 4'd0 : r_rx_tcnt + 4'd1;
         if (r_rx_st == RX_DATA) begin
            if (w_rx_samp)    r_rx_sh   <= {r_rx_s2, r_rx_sh[DATA_W-1:1]};
            if (w_rx_bit_end) r_rx_bcnt <= r_rx_bcnt + 4'd1;
         end else begin
            r_rx_bcnt <= '0;
         end
         if (r_rx_st == RX_PAR && w_rx_samp) r_rx_par_s <= r_rx_s2;
      end
   end

   assign rx_break_o = r_rx_break;

   // RX FIFO: entry = {frame_err, parity_err, data}
   logic [DATA_W+1:0] r_rxf_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_rxf_wp, r_rxf_rp;
   logic [AW:0]       r_rxf_cnt;
   logic              r_rx_ovr, w_rxf_full, w_rxf_empty, w_rxf_wr, w_rxf_rd;
   logic [DATA_W+1:0] w_rxf_head;

   assign w_rxf_full  = (r_rxf_cnt == CNT_FULL);
   assign w_rxf_empty = (r_rxf_cnt == '0);
   assign w_rxf_rd    = rx_ready_i && !w_rxf_empty;
   assign w_rxf_wr    = w_rx_push && (!w_rxf_full || w_rxf_rd);
   assign w_rxf_head  = r_rxf_mem[r_rxf_rp];

   always_ff @(posedge clk) begin
      if (w_rxf_wr) r_rxf_mem[r_rxf_wp] <= {!r_rx_s2, w_rx_par_err, r_rx_sh};
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         r_rxf_wp  <= '0;
         r_rxf_rp  <= '0;
         r_rxf_cnt <= '0;
         r_rx_ovr  <= 1'b0;
      end else begin
         if (w_rxf_wr) r_rxf_wp <= r_rxf_wp + PTR_ONE;
         if (w_rxf_rd) r_rxf_rp <= r_rxf_rp + PTR_ONE;
         case ({w_rxf_wr, w_rxf_rd})
            2'b10:   r_rxf_cnt <= r_rxf_cnt + CNT_ONE;
            2'b01:   r_rxf_cnt <= r_rxf_cnt - CNT_ONE;
            default: r_rxf_cnt <= r_rxf_cnt;
         endcase
         if (w_rx_push && w_rxf_full && !w_rxf_rd) r_rx_ovr <= 1'b1;
      end
   end

   assign rx_data_o       = w_rxf_head[DATA_W-1:0];
   assign rx_parity_err_o = w_rxf_head[DATA_W];
   assign rx_frame_err_o  = w_rxf_head[DATA_W+1];
   assign rx_valid_o      = !w_rxf_empty;
   assign rx_level_o      = r_rxf_cnt;
   assign rx_overrun_o    = r_rx_ovr;

endmodule

// File: tb/tb_uart_param_core.sv
// Directed bench for uart_param_core: TX waveform, loopback, RX error tags, break,
// overrun and reset/glitch behaviour at P=4, N=8 (32 clocks per bit).
module tb_uart_param_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cfg_acq_period_i;
   logic [3:0]  cfg_acq_per_bit_i;
   logic        cfg_parity_en_i, cfg_parity_odd_i, cfg_stop2_i, cfg_loopback_i;
   logic        clr_i;
   logic [7:0]  tx_data_i;
   logic        tx_valid_i, tx_ready_o, tx_busy_o;
   logic [4:0]  tx_level_o, rx_level_o;
   logic [7:0]  rx_data_o;
   logic        rx_parity_err_o, rx_frame_err_o, rx_valid_o, rx_ready_i;
   logic        rx_overrun_o, rx_break_o, rx_i, tx_o;

   int checks = 0;
   int failures = 0;

   uart_param_core #(.DATA_W(8), .FIFO_DEPTH(16), .ACQ_W(16)) dut (
      .clk(clk), .rst(rst),
      .cfg_acq_period_i(cfg_acq_period_i), .cfg_acq_per_bit_i(cfg_acq_per_bit_i),
      .cfg_parity_en_i(cfg_parity_en_i), .cfg_parity_odd_i(cfg_parity_odd_i),
      .cfg_stop2_i(cfg_stop2_i), .cfg_loopback_i(cfg_loopback_i), .clr_i(clr_i),
      .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .tx_level_o(tx_level_o), .tx_busy_o(tx_busy_o),
      .rx_data_o(rx_data_o), .rx_parity_err_o(rx_parity_err_o),
      .rx_frame_err_o(rx_frame_err_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
      .rx_level_o(rx_level_o), .rx_overrun_o(rx_overrun_o), .rx_break_o(rx_break_o),
      .rx_i(rx_i), .tx_o(tx_o)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pop_rx();
      rx_ready_i = 1'b1;
      step(1);
      rx_ready_i = 1'b0;
   endtask

   // bit-banged frame on rx_i, 32 clocks per bit
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic sbit);
      rx_i = 1'b0;
      step(32);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         step(32);
      end
      if (pen) begin
         rx_i = pbit;
         step(32);
      end
      rx_i = sbit;
      step(32);
      rx_i = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      step(1);
      checks++; if (tx_o !== 1'b1) begin failures++; $display("FAIL reset_tx_o got=%b exp=1", tx_o); end
      checks++; if (tx_busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy_o); end
      checks++; if (tx_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tx_ready_o); end
      checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid_o); end
      checks++; if (tx_level_o !== 5'd0 || rx_level_o !== 5'd0) begin
         failures++; $display("FAIL reset_levels tx=%0d rx=%0d exp=0/0", tx_level_o, rx_level_o); end
      checks++; if (rx_overrun_o !== 1'b0 || rx_break_o !== 1'b0) begin
         failures++; $display("FAIL reset_flags ovr=%b brk=%b exp=0/0", rx_overrun_o, rx_break_o); end
   endtask

   task automatic test_tx_frame();
      logic       rec [400];
      logic [9:0] fr;
      int         busy_cnt, first_low, bad;
      fr = {1'b1, 8'hA5, 1'b0};
      busy_cnt = 0;
      first_low = -1;
      tx_data_i = 8'hA5;
      tx_valid_i = 1'b1;
      step(1);
      tx_valid_i = 1'b0;
      for (int c = 0; c < 400; c++) begin
         rec[c] = tx_o;
         if (tx_busy_o) busy_cnt++;
         if (first_low < 0 && tx_o == 1'b0) first_low = c;
         step(1);
      end
      checks++;
      if (first_low < 0 || first_low > 20) begin
         failures++; $display("FAIL tx_start_found got=%0d exp=0..20", first_low);
         first_low = 0;
      end
      for (int b = 0; b < 10; b++) begin
         bad = 0;
         for (int k = 0; k < 32; k++)
            if (rec[first_low + b*32 + k] !== fr[b]) bad++;
         checks++;
         if (bad != 0) begin
            failures++; $display("FAIL tx_bit%0d wrong_cycles=%0d exp_level=%b", b, bad, fr[b]);
         end
      end
      checks++; if (rec[first_low + 320] !== 1'b1) begin
         failures++; $display("FAIL tx_after_stop got=%b exp=1", rec[first_low + 320]); end
      checks++; if (busy_cnt != 320) begin
         failures++; $display("FAIL tx_busy_len got=%0d exp=320", busy_cnt); end
      checks++; if (tx_busy_o !== 1'b0) begin
         failures++; $display("FAIL tx_busy_end got=%b exp=0", tx_busy_o); end
   endtask

   task automatic test_loopback();
      int tx_bad, peak;
      tx_bad = 0;
      peak = 0;
      cfg_loopback_i = 1'b1;
      cfg_parity_en_i = 1'b1;
      cfg_parity_odd_i = 1'b1;
      cfg_stop2_i = 1'b1;
      tx_valid_i = 1'b1;
      tx_data_i = 8'h03;
      step(1);
      tx_data_i = 8'h80;
      step(1);
      tx_valid_i = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         if (tx_o !== 1'b1) tx_bad++;
         if (int'(rx_level_o) > peak) peak = int'(rx_level_o);
         step(1);
      end
      checks++; if (tx_bad != 0) begin failures++; $display("FAIL lb_tx_o_low cycles=%0d exp=0", tx_bad); end
      checks++; if (peak != 2) begin failures++; $display("FAIL lb_peak got=%0d exp=2", peak); end
      checks++; if (rx_data_o !== 8'h03 || rx_parity_err_o !== 1'b0 || rx_frame_err_o !== 1'b0) begin
         failures++; $display("FAIL lb_first got=%h p=%b f=%b exp=03 0 0",
                              rx_data_o, rx_parity_err_o, rx_frame_err_o); end
      pop_rx();
      checks++; if (rx_data_o !== 8'h80 || rx_parity_err_o !== 1'b0 || rx_frame_err_o !== 1'b0) begin
         failures++; $display("FAIL lb_second got=%h p=%b f=%b exp=80 0 0",
                              rx_data_o, rx_parity_err_o, rx_frame_err_o); end
      pop_rx();
      checks++; if (rx_level_o !== 5'd0) begin failures++; $display("FAIL lb_drain got=%0d exp=0", rx_level_o); end
      cfg_loopback_i = 1'b0;
      cfg_parity_en_i = 1'b0;
      cfg_parity_odd_i = 1'b0;
      cfg_stop2_i = 1'b0;
      step(64);
   endtask

   task automatic test_rx_errors();
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      step(40);
      checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h5A || rx_frame_err_o !== 1'b1 ||
                    rx_parity_err_o !== 1'b0) begin
         failures++; $display("FAIL rx_frame_err v=%b d=%h f=%b p=%b exp=1 5a 1 0",
                              rx_valid_o, rx_data_o, rx_frame_err_o, rx_parity_err_o); end
      pop_rx();
      cfg_parity_en_i = 1'b1;
      send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
      step(8);
      checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h5A || rx_frame_err_o !== 1'b0 ||
                    rx_parity_err_o !== 1'b1) begin
         failures++; $display("FAIL rx_parity_err v=%b d=%h f=%b p=%b exp=1 5a 0 1",
                              rx_valid_o, rx_data_o, rx_frame_err_o, rx_parity_err_o); end
      pop_rx();
      cfg_parity_en_i = 1'b0;
      checks++; if (rx_level_o !== 5'd0) begin failures++; $display("FAIL rx_err_drain got=%0d exp=0", rx_level_o); end
   endtask

   task automatic test_break();
      int brk, vld;
      brk = 0;
      vld = 0;
      rx_i = 1'b0;
      for (int c = 0; c < 384; c++) begin
         if (rx_break_o) brk++;
         if (rx_valid_o) vld++;
         step(1);
      end
      rx_i = 1'b1;
      for (int c = 0; c < 64; c++) begin
         if (rx_break_o) brk++;
         if (rx_valid_o) vld++;
         step(1);
      end
      checks++; if (brk != 1) begin failures++; $display("FAIL break_pulses got=%0d exp=1", brk); end
      checks++; if (vld != 0) begin failures++; $display("FAIL break_no_write valid_cycles=%0d exp=0", vld); end
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      step(4);
      checks++; if (rx_level_o !== 5'd1 || rx_data_o !== 8'h11 || rx_frame_err_o !== 1'b0 ||
                    rx_parity_err_o !== 1'b0) begin
         failures++; $display("FAIL break_recover lvl=%0d d=%h f=%b p=%b exp=1 11 0 0",
                              rx_level_o, rx_data_o, rx_frame_err_o, rx_parity_err_o); end
      pop_rx();
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 17; i++) begin
         send_frame(8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
         if (i == 15) begin
            step(2);
            checks++; if (rx_level_o !== 5'd16 || rx_overrun_o !== 1'b0) begin
               failures++; $display("FAIL ovr_full lvl=%0d ovr=%b exp=16 0", rx_level_o, rx_overrun_o); end
         end
      end
      step(4);
      checks++; if (rx_level_o !== 5'd16 || rx_overrun_o !== 1'b1) begin
         failures++; $display("FAIL ovr_set lvl=%0d ovr=%b exp=16 1", rx_level_o, rx_overrun_o); end
      checks++; if (rx_data_o !== 8'h20) begin failures++; $display("FAIL ovr_head got=%h exp=20", rx_data_o); end
      clr_i = 1'b1;
      tx_data_i = 8'h77;
      tx_valid_i = 1'b1;
      step(1);
      clr_i = 1'b0;
      tx_valid_i = 1'b0;
      checks++; if (rx_level_o !== 5'd0 || rx_overrun_o !== 1'b0 || rx_valid_o !== 1'b0) begin
         failures++; $display("FAIL clr_rx lvl=%0d ovr=%b v=%b exp=0 0 0", rx_level_o, rx_overrun_o, rx_valid_o); end
      checks++; if (tx_level_o !== 5'd0) begin failures++; $display("FAIL clr_tx_priority got=%0d exp=0", tx_level_o); end
   endtask

   task automatic test_reset_mid_frame();
      int low_at, vld;
      low_at = -1;
      vld = 0;
      tx_valid_i = 1'b1;
      tx_data_i = 8'h11; step(1);
      tx_data_i = 8'h22; step(1);
      tx_data_i = 8'h33; step(1);
      tx_valid_i = 1'b0;
      for (int c = 0; c < 40 && low_at < 0; c++) begin
         if (tx_o == 1'b0) low_at = c;
         else step(1);
      end
      checks++; if (low_at < 0) begin failures++; $display("FAIL rstmid_start got=none exp=start bit"); end
      step(50);
      checks++; if (tx_busy_o !== 1'b1 || tx_level_o !== 5'd2) begin
         failures++; $display("FAIL rstmid_pre busy=%b lvl=%0d exp=1 2", tx_busy_o, tx_level_o); end
      rst = 1'b1;
      step(1);
      checks++; if (tx_o !== 1'b1 || tx_level_o !== 5'd0 || tx_busy_o !== 1'b0 || tx_ready_o !== 1'b1) begin
         failures++; $display("FAIL rstmid_post tx_o=%b lvl=%0d busy=%b rdy=%b exp=1 0 0 1",
                              tx_o, tx_level_o, tx_busy_o, tx_ready_o); end
      rst = 1'b0;
      step(4);
      rx_i = 1'b0;
      step(1);
      rx_i = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (rx_valid_o) vld++;
         step(1);
      end
      checks++; if (vld != 0 || rx_level_o !== 5'd0) begin
         failures++; $display("FAIL glitch_false_start valid_cycles=%0d lvl=%0d exp=0 0", vld, rx_level_o); end
   endtask

   initial begin
      rst = 1'b1;
      cfg_acq_period_i = 16'd4;
      cfg_acq_per_bit_i = 4'd8;
      cfg_parity_en_i = 1'b0;
      cfg_parity_odd_i = 1'b0;
      cfg_stop2_i = 1'b0;
      cfg_loopback_i = 1'b0;
      clr_i = 1'b0;
      tx_data_i = '0;
      tx_valid_i = 1'b0;
      rx_ready_i = 1'b0;
      rx_i = 1'b1;
      test_reset();
      test_tx_frame();
      test_loopback();
      test_rx_errors();
      test_break();
      test_overrun();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
